// File: rtl/fnd_scan_ctrl_if.sv
// Display-path bundle between the stopwatch datapath and the FND scan controller.
// Signal directions are named from the scan controller's point of view.
interface fnd_scan_ctrl_if;
   logic       i_sw;
   logic [6:0] i_msec;
   logic [5:0] i_sec;
   logic [5:0] i_min;
   logic [4:0] i_hour;
   logic [7:0] o_fnd_data;
   logic [3:0] o_fnd_com;

   modport master (
      output i_sw, i_msec, i_sec, i_min, i_hour,
      input  o_fnd_data, o_fnd_com
   );

   modport slave (
      input  i_sw, i_msec, i_sec, i_min, i_hour,
      output o_fnd_data, o_fnd_com
   );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with inter-digit
// blanking and a decimal point that blinks with the hundredths count.
module fnd_scan_ctrl #(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned SCAN_HZ   = 1000,
   parameter int unsigned BLANK_CYC = 4
) (
   input logic            clk,
   input logic            rst_n,
   fnd_scan_ctrl_if.slave bus
);
   localparam int unsigned   DIV       = CLK_HZ / SCAN_HZ;
   localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

   logic [PW-1:0] r_presc;
   logic [1:0]    r_d;
   logic [7:0]    r_fnd_data;
   logic [3:0]    r_fnd_com;

   logic       w_tick;
   logic       w_blank;
   logic [6:0] w_msec_c;
   logic [6:0] w_sec_c;
   logic [6:0] w_min_c;
   logic [6:0] w_hour_c;
   logic [6:0] w_hi;
   logic [6:0] w_lo;
   logic [6:0] w_digit;
   logic       w_dp_n;
   logic [7:0] w_data;
   logic [3:0] w_com;

   function automatic logic [6:0] seg7(input logic [6:0] v);
      case (v)
         7'd0:    seg7 = 7'h40;
         7'd1:    seg7 = 7'h79;
         7'd2:    seg7 = 7'h24;
         7'd3:    seg7 = 7'h30;
         7'd4:    seg7 = 7'h19;
         7'd5:    seg7 = 7'h12;
         7'd6:    seg7 = 7'h02;
         7'd7:    seg7 = 7'h78;
         7'd8:    seg7 = 7'h00;
         7'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   assign w_tick  = (r_presc == DIV_LAST);
   assign w_blank = (r_presc < BLANK_END);

   // Out-of-range counts are pinned to their nominal maximum before the split.
   assign w_msec_c = (bus.i_msec > 7'd99) ? 7'd99 : bus.i_msec;
   assign w_sec_c  = (bus.i_sec  > 6'd59) ? 7'd59 : {1'b0, bus.i_sec};
   assign w_min_c  = (bus.i_min  > 6'd59) ? 7'd59 : {1'b0, bus.i_min};
   assign w_hour_c = (bus.i_hour > 5'd23) ? 7'd23 : {2'b00, bus.i_hour};

   assign w_hi = bus.i_sw ? w_hour_c : w_sec_c;
   assign w_lo = bus.i_sw ? w_min_c  : w_msec_c;

   always_comb begin
      w_digit = 7'd0;
      case (r_d)
         2'd3:    w_digit = w_hi / 7'd10;
         2'd2:    w_digit = w_hi % 7'd10;
         2'd1:    w_digit = w_lo / 7'd10;
         default: w_digit = w_lo % 7'd10;
      endcase
   end

   // The dp tracks the first half of each second regardless of the selected field.
   assign w_dp_n = !((r_d == 2'd2) && (w_msec_c < 7'd50));
   assign w_data = {w_dp_n, seg7(w_digit)};
   assign w_com  = w_blank ? 4'b1111 : ~(4'b0001 << r_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc    <= '0;
         r_d        <= 2'd0;
         r_fnd_data <= 8'hFF;
         r_fnd_com  <= 4'b1111;
      end else begin
         r_presc    <= w_tick ? '0 : r_presc + PW'(1);
         r_d        <= w_tick ? r_d + 2'd1 : r_d;
         r_fnd_data <= w_data;
         r_fnd_com  <= w_com;
      end
   end

   assign bus.o_fnd_data = r_fnd_data;
   assign bus.o_fnd_com  = r_fnd_com;
endmodule
